// File: rtl/conv2d_scheduler_if.sv
// -----------------------------------------------------------------------------
// conv2d_scheduler_if
//   Control bundle between the conv2d sequencing controller and the rest of the
//   convolution datapath (buffers, MAC, result consumer).
//
//   master modport (scheduler side):
//     in : start      one-cycle run request
//          out_ready  consumer accepts the presented result
//     out: busy, done run status
//          in_addr, wt_addr, bias_addr   buffer read addresses (1-cycle latency)
//          acc_init, mac_en, mac_pad     accumulator strobes (aligned to data)
//          out_valid, out_addr           result write port
//          cycle_cnt, stall_cnt          only when CONV_SCHED_PERF_EN is defined
//   slave modport: the mirror image, for the datapath/consumer side.
//
//   The parameters must match those of the conv2d_scheduler instance so that
//   the address widths agree.
// -----------------------------------------------------------------------------
interface conv2d_scheduler_if #(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 3,
  parameter int OUT_CHANNELS = 4,
  parameter int IN_HEIGHT    = 8,
  parameter int IN_WIDTH     = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1
);
  localparam int OUT_HEIGHT = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
  localparam int IN_N  = BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH;
  localparam int WT_N  = OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE;
  localparam int OUT_N = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH;
  localparam int IN_AW  = (IN_N  > 1) ? $clog2(IN_N)  : 1;
  localparam int WT_AW  = (WT_N  > 1) ? $clog2(WT_N)  : 1;
  localparam int B_AW   = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int OUT_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  logic              start;
  logic              busy;
  logic              done;
  logic [IN_AW-1:0]  in_addr;
  logic [WT_AW-1:0]  wt_addr;
  logic [B_AW-1:0]   bias_addr;
  logic              acc_init;
  logic              mac_en;
  logic              mac_pad;
  logic              out_valid;
  logic [OUT_AW-1:0] out_addr;
  logic              out_ready;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]       cycle_cnt;
  logic [31:0]       stall_cnt;
`endif

  modport master (
    input  start,
    input  out_ready,
    output busy,
    output done,
    output in_addr,
    output wt_addr,
    output bias_addr,
    output acc_init,
    output mac_en,
    output mac_pad,
    output out_valid,
    output out_addr
`ifdef CONV_SCHED_PERF_EN
    ,
    output cycle_cnt,
    output stall_cnt
`endif
  );

  modport slave (
    output start,
    output out_ready,
    input  busy,
    input  done,
    input  in_addr,
    input  wt_addr,
    input  bias_addr,
    input  acc_init,
    input  mac_en,
    input  mac_pad,
    input  out_valid,
    input  out_addr
`ifdef CONV_SCHED_PERF_EN
    ,
    input  cycle_cnt,
    input  stall_cnt
`endif
  );
endinterface

// File: rtl/conv2d_scheduler.sv
// -----------------------------------------------------------------------------
// conv2d_scheduler
//   Sequencing controller for the conv2d datapath. A start pulse walks every
//   output element in (batch, out-channel, row, column) order. Per element:
//   one BIAS cycle, one TAP cycle per kernel tap (ic outer, ky, kx inner), one
//   DRAIN cycle for the last MAC, then WRITE until the consumer accepts.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-low reset
//     bus  conv2d_scheduler_if.master (start/busy/done, buffer addresses,
//          MAC strobes, valid/ready result port)
//
//   Optional build macro CONV_SCHED_PERF_EN adds saturating 32-bit cycle_cnt
//   (busy cycles) and stall_cnt (out_valid & ~out_ready cycles) to the bus.
// -----------------------------------------------------------------------------
module conv2d_scheduler #(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 3,
  parameter int OUT_CHANNELS = 4,
  parameter int IN_HEIGHT    = 8,
  parameter int IN_WIDTH     = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1
) (
  input  logic               clk,
  input  logic               rst,
  conv2d_scheduler_if.master bus
);
  localparam int OUT_HEIGHT = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
  localparam int IN_N  = BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH;
  localparam int WT_N  = OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE;
  localparam int OUT_N = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH;
  localparam int IN_AW  = (IN_N  > 1) ? $clog2(IN_N)  : 1;
  localparam int WT_AW  = (WT_N  > 1) ? $clog2(WT_N)  : 1;
  localparam int B_AW   = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int OUT_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_TAP, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_b, r_oc, r_oy, r_ox, r_ic, r_ky, r_kx;
  logic        r_busy, r_done, r_acc_init, r_mac_en, r_mac_pad;

  int   w_iy, w_ix;
  logic w_pad, w_last_tap, w_last_elem, w_start_ok;

  // NOTE: every variable gets a value on every pass through this block, so no latch is inferred.
  always_comb begin
    // Signed tap coordinates; negative or past-the-edge means the padding border.
    w_iy = int'(r_oy)*STRIDE + int'(r_ky) - PADDING;
    w_ix = int'(r_ox)*STRIDE + int'(r_kx) - PADDING;
    w_pad = (w_iy < 0) || (w_iy >= IN_HEIGHT) || (w_ix < 0) || (w_ix >= IN_WIDTH);
    w_last_tap = (r_ic == 32'(IN_CHANNELS-1)) && (r_ky == 32'(KERNEL_SIZE-1)) &&
                 (r_kx == 32'(KERNEL_SIZE-1));
    w_last_elem = (r_b == 32'(BATCH_SIZE-1)) && (r_oc == 32'(OUT_CHANNELS-1)) &&
                  (r_oy == 32'(OUT_HEIGHT-1)) && (r_ox == 32'(OUT_WIDTH-1));
    // The cycle that shows done is still part of the run, so start is ignored there too.
    w_start_ok = (r_state == S_IDLE) && !r_done && bus.start;
  end

  // NOTE: the async reset clears every control register; there is no storage array to leave unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_b        <= '0;
      r_oc       <= '0;
      r_oy       <= '0;
      r_ox       <= '0;
      r_ic       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_acc_init <= 1'b0;
      r_mac_en   <= 1'b0;
      r_mac_pad  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here sees pre-edge values.
      // Strobes trail their address by one cycle to line up with the buffer read data.
      r_done     <= (r_state == S_DONE);
      r_acc_init <= (r_state == S_BIAS);
      r_mac_en   <= (r_state == S_TAP);
      r_mac_pad  <= (r_state == S_TAP) && w_pad;

      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_busy  <= 1'b1;
            r_b     <= '0;
            r_oc    <= '0;
            r_oy    <= '0;
            r_ox    <= '0;
            r_ic    <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_state <= S_BIAS;
          end
        end
        S_BIAS: r_state <= S_TAP;
        S_TAP: begin
          if (r_kx == 32'(KERNEL_SIZE-1)) begin
            r_kx <= '0;
            if (r_ky == 32'(KERNEL_SIZE-1)) begin
              r_ky <= '0;
              if (r_ic == 32'(IN_CHANNELS-1)) r_ic <= '0;
              else                            r_ic <= r_ic + 32'd1;
            end else begin
              r_ky <= r_ky + 32'd1;
            end
          end else begin
            r_kx <= r_kx + 32'd1;
          end
          if (w_last_tap) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_WRITE;
        S_WRITE: begin
          if (bus.out_ready) begin
            if (r_ox == 32'(OUT_WIDTH-1)) begin
              r_ox <= '0;
              if (r_oy == 32'(OUT_HEIGHT-1)) begin
                r_oy <= '0;
                if (r_oc == 32'(OUT_CHANNELS-1)) begin
                  r_oc <= '0;
                  if (r_b == 32'(BATCH_SIZE-1)) r_b <= '0;
                  else                          r_b <= r_b + 32'd1;
                end else begin
                  r_oc <= r_oc + 32'd1;
                end
              end else begin
                r_oy <= r_oy + 32'd1;
              end
            end else begin
              r_ox <= r_ox + 32'd1;
            end
            r_state <= w_last_elem ? S_DONE : S_BIAS;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.acc_init  = r_acc_init;
  assign bus.mac_en    = r_mac_en;
  assign bus.mac_pad   = r_mac_pad;
  assign bus.out_valid = (r_state == S_WRITE);
  // Addresses are decoded from the registered state/counters and forced to 0
  // outside their issuing state (and on padded taps for the input buffer).
  assign bus.bias_addr = (r_state == S_BIAS) ? B_AW'(r_oc) : '0;
  assign bus.in_addr   = (r_state == S_TAP && !w_pad) ?
      IN_AW'(((int'(r_b)*IN_CHANNELS + int'(r_ic))*IN_HEIGHT + w_iy)*IN_WIDTH + w_ix) : '0;
  assign bus.wt_addr   = (r_state == S_TAP) ?
      WT_AW'(((int'(r_oc)*IN_CHANNELS + int'(r_ic))*KERNEL_SIZE + int'(r_ky))*KERNEL_SIZE
             + int'(r_kx)) : '0;
  assign bus.out_addr  = (r_state == S_WRITE) ?
      OUT_AW'(((int'(r_b)*OUT_CHANNELS + int'(r_oc))*OUT_HEIGHT + int'(r_oy))*OUT_WIDTH
              + int'(r_ox)) : '0;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] r_cycle_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_busy && (r_cycle_cnt != '1)) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if ((r_state == S_WRITE) && !bus.out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`else
  // Performance counters not built; the bus carries no counter signals.
`endif
endmodule

// File: tb/tb_conv2d_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv2d_scheduler
//   Directed bench for conv2d_scheduler. A default-parameter instance runs four
//   scenarios (clean run, backpressure + start re-pulse, mid-run reset, clean
//   run with start offered around done); a STRIDE=2 instance runs alongside the
//   first. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_conv2d_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv2d_scheduler_if              bus  ();
  conv2d_scheduler_if #(.STRIDE(2)) bus2 ();

  conv2d_scheduler              u_dut    (.clk(clk), .rst(rst), .bus(bus));
  conv2d_scheduler #(.STRIDE(2)) u_dut_s2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},      bus.busy,      0);
    check({tag, " done"},      bus.done,      0);
    check({tag, " out_valid"}, bus.out_valid, 0);
    check({tag, " acc_init"},  bus.acc_init,  0);
    check({tag, " mac_en"},    bus.mac_en,    0);
    check({tag, " mac_pad"},   bus.mac_pad,   0);
    check({tag, " in_addr"},   bus.in_addr,   0);
    check({tag, " wt_addr"},   bus.wt_addr,   0);
    check({tag, " bias_addr"}, bus.bias_addr, 0);
    check({tag, " out_addr"},  bus.out_addr,  0);
  endtask

  // One run of the default instance. stall_at < 0 disables backpressure,
  // repulse_at/abort_at < 0 disable those events.
  task automatic do_run(input string tag, input int stall_at, input int repulse_at,
                        input int abort_at, input bit with_s2, input bit start_in_done,
                        input int exp_busy);
    int cyc = 0, writes = 0, busy_cyc = 0, done_cnt = 0, last_hs = -100, base = -100;
    int hold = 0, stall_left = 5, el0_mac = 0, el0_pad = 0;
    int s_writes = 0, s_done = 0, s_base = -100;
    int prev_bias = 0;
    bit fin = 0, aborted = 0;

    bus.start = 1'b1;
    if (with_s2) bus2.start = 1'b1;
    while (!fin && cyc < 9000) begin
      tick();
      cyc++;
      bus.start  = 1'b0;
      bus2.start = 1'b0;
      if (cyc == repulse_at) bus.start = 1'b1;

      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        check_idle({tag, " abort"});
        aborted = 1;
        fin = 1;
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid && writes == stall_at && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end
        if (bus.busy) busy_cyc++;

        // acc_init marks the cycle in which tap 0 of the current element issues.
        if (bus.acc_init) begin
          base = cyc;
          if (writes == 92) check({tag, " e92 bias_addr"}, prev_bias, 1);
        end
        if (writes == 0) begin
          if (bus.mac_en) el0_mac++;
          if (bus.mac_en && bus.mac_pad) el0_pad++;
          if (cyc == base)     check({tag, " e0 t0 in_addr"}, bus.in_addr, 0);
          if (cyc == base + 1) check({tag, " e0 t0 mac_pad"}, bus.mac_pad, 1);
          if (cyc == base + 4) begin
            check({tag, " e0 t4 in_addr"}, bus.in_addr, 0);
            check({tag, " e0 t4 wt_addr"}, bus.wt_addr, 4);
          end
          if (cyc == base + 5) begin
            check({tag, " e0 t4 mac_en"},  bus.mac_en,  1);
            check({tag, " e0 t4 mac_pad"}, bus.mac_pad, 0);
          end
        end
        // Element 92 = (oc=1, oy=3, ox=4); tap 24 = (ic=2, ky=2, kx=0):
        // iy=4, ix=3 -> (2*8+4)*8+3 = 163; wt ((1*3+2)*3+2)*3+0 = 51.
        if (writes == 92) begin
          if (cyc == base + 24) begin
            check({tag, " e92 t24 in_addr"}, bus.in_addr, 163);
            check({tag, " e92 t24 wt_addr"}, bus.wt_addr, 51);
          end
          if (cyc == base + 25) begin
            check({tag, " e92 t24 mac_en"},  bus.mac_en,  1);
            check({tag, " e92 t24 mac_pad"}, bus.mac_pad, 0);
          end
        end
        prev_bias = int'(bus.bias_addr);

        if (bus.out_valid && writes == stall_at) begin
          hold++;
          check({tag, " hold out_addr"}, bus.out_addr, stall_at);
          check({tag, " hold mac_en"},   bus.mac_en,   0);
          check({tag, " hold acc_init"}, bus.acc_init, 0);
        end
        if (bus.out_valid && bus.out_ready) begin
          check({tag, " out_addr"}, bus.out_addr, writes);
          writes++;
          last_hs = cyc;
        end
        if (start_in_done && writes == 256 && cyc == last_hs + 1) bus.start = 1'b1;
        if (bus.done) begin
          done_cnt++;
          check({tag, " done gap"}, cyc - last_hs, 2);
          check({tag, " busy at done"}, bus.busy, 0);
          if (start_in_done) bus.start = 1'b1;
          fin = 1;
        end

        if (with_s2) begin
          if (bus2.acc_init) s_base = cyc;
          // Element 5 = (oc=0, oy=1, ox=1); tap 0: iy=ix=1 -> 1*8+1 = 9.
          if (s_writes == 5 && cyc == s_base)     check("s2 e5 t0 in_addr", bus2.in_addr, 9);
          if (s_writes == 5 && cyc == s_base + 1) check("s2 e5 t0 mac_pad", bus2.mac_pad, 0);
          if (bus2.out_valid && bus2.out_ready) begin
            check("s2 out_addr", bus2.out_addr, s_writes);
            s_writes++;
          end
          if (bus2.done) s_done++;
        end
      end
    end

    if (aborted) begin
      repeat (3) begin
        tick();
        check({tag, " no done in reset"}, bus.done, 0);
      end
      rst = 1'b1;
      repeat (2) tick();
      check_idle({tag, " after abort"});
    end else begin
      check({tag, " done count"}, done_cnt, 1);
      check({tag, " writes"},     writes,   256);
      check({tag, " busy cycles"}, busy_cyc, exp_busy);
      check({tag, " e0 mac_en"},  el0_mac,  27);
      check({tag, " e0 padded"},  el0_pad,  15);
      if (stall_at >= 0) check({tag, " hold cycles"}, hold, 6);
      if (with_s2) begin
        check("s2 writes", s_writes, 64);
        check("s2 done",   s_done,   1);
      end
      tick();
      bus.start = 1'b0;
      check({tag, " busy after"}, bus.busy, 0);
      check({tag, " done after"}, bus.done, 0);
`ifdef CONV_SCHED_PERF_EN
      repeat (3) tick();
      check({tag, " cycle_cnt"}, bus.cycle_cnt, exp_busy);
      check({tag, " stall_cnt"}, bus.stall_cnt, (stall_at >= 0) ? 5 : 0);
`endif
      repeat (2) tick();
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.start     = 1'b0;
    bus2.out_ready = 1'b1;
    repeat (3) tick();
    check_idle("reset");
    check("reset s2 busy",      bus2.busy,      0);
    check("reset s2 out_valid", bus2.out_valid, 0);
    rst = 1'b1;
    repeat (2) tick();
    check_idle("idle");

    do_run("run1", -1, -1,  -1, 1'b1, 1'b0, 256*30 + 1);
    do_run("run2",  3, 100, -1, 1'b0, 1'b0, 256*30 + 1 + 5);
    do_run("run3", -1, -1, 500, 1'b0, 1'b0, 0);
    do_run("run4", -1, -1,  -1, 1'b0, 1'b1, 256*30 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
